// File: rtl/pipeline_hazard_controller.sv
// Hazard/halt controller for a 5-stage pipeline: load-use stall, taken-branch flush, halt/drain FSM.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module pipeline_hazard_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic [3:0]  ex_rd,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic        id_branch_taken,
  input  logic        halt_req,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        if_id_flush,
  output logic        nop_select,
  output logic        halt_ack,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] drain_cnt;
  logic [1:0] drain_cnt_next;
  logic       load_use;

  assign load_use = ex_mem_to_reg & ex_reg_write &
                    ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    pc_enable      = 1'b1;
    if_id_enable   = 1'b1;
    if_id_flush    = 1'b0;
    nop_select     = 1'b0;
    halt_ack       = 1'b0;
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      RUN: begin
        if (load_use) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          nop_select   = 1'b1;
        end else if (id_branch_taken) begin
          if_id_flush = 1'b1;
        end else if (halt_req) begin
          // Stop fetching; the instruction already in ID still moves on to EX.
          pc_enable      = 1'b0;
          if_id_flush    = 1'b1;
          state_next     = DRAIN;
          drain_cnt_next = 2'd3;
        end
      end
      DRAIN: begin
        pc_enable      = 1'b0;
        if_id_enable   = 1'b0;
        nop_select     = 1'b1;
        drain_cnt_next = drain_cnt - 2'd1;
        if (drain_cnt <= 2'd1) begin
          state_next     = HALTED;
          drain_cnt_next = 2'd0;
        end
      end
      HALTED: begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        nop_select   = 1'b1;
        halt_ack     = 1'b1;
        if (!halt_req) state_next = RUN;
      end
      default: begin
        state_next     = RUN;
        drain_cnt_next = 2'd0;
      end
    endcase
    // While reset is held the pipeline sees plain RUN behaviour whatever the inputs.
    if (!reset) begin
      pc_enable    = 1'b1;
      if_id_enable = 1'b1;
      if_id_flush  = 1'b0;
      nop_select   = 1'b0;
      halt_ack     = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic        stall_event;
  logic        flush_event;
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  assign stall_event = reset & (state == RUN) & load_use;
  assign flush_event = reset & (state == RUN) & ~load_use & id_branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (stall_event && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_event && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = 16'd0;
  assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: driver pushes expected outputs, negedge monitor compares.
module tb_pipeline_hazard_controller;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int W = 39;
  // ctrl = {pc_enable, if_id_enable, if_id_flush, nop_select, halt_ack, fsm_state[1:0]}
  localparam logic [6:0] C_IDLE   = 7'b11000_00;
  localparam logic [6:0] C_STALL  = 7'b00010_00;
  localparam logic [6:0] C_BRANCH = 7'b11100_00;
  localparam logic [6:0] C_HENTRY = 7'b01100_00;
  localparam logic [6:0] C_DRAIN  = 7'b00010_01;
  localparam logic [6:0] C_HALTED = 7'b00011_10;

  logic        clk;
  logic        reset;
  logic [3:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rn, id_uses_rm, ex_mem_to_reg, ex_reg_write;
  logic        id_branch_taken, halt_req;
  logic        pc_enable, if_id_enable, if_id_flush, nop_select, halt_ack;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  fsm_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests = 0;
  int           fails = 0;
  logic [15:0]  exp_stall = 16'd0;
  logic [15:0]  exp_flush = 16'd0;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .id_branch_taken(id_branch_taken), .halt_req(halt_req),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .nop_select(nop_select), .halt_ack(halt_ack),
    .stall_count(stall_count), .flush_count(flush_count), .fsm_state(fsm_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] actual();
    return {pc_enable, if_id_enable, if_id_flush, nop_select, halt_ack, fsm_state,
            stall_count, flush_count};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = actual();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got ctrl=%b stall=%h flush=%h, expected ctrl=%b stall=%h flush=%h",
               nm, act[38:32], act[31:16], act[15:0], exp[38:32], exp[31:16], exp[15:0]);
    end
  endtask

  // monitor: every cycle with a pending expectation is compared at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) chk(name_q.pop_front(), exp_q.pop_front());
  end

  // driver tasks
  task automatic set_in(input logic [3:0] rn, input logic [3:0] rm, input logic urn,
                        input logic urm, input logic [3:0] rd, input logic mtr,
                        input logic rw, input logic br, input logic hr);
    id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
    ex_rd = rd; ex_mem_to_reg = mtr; ex_reg_write = rw;
    id_branch_taken = br; halt_req = hr;
  endtask

  task automatic idle_in(input logic hr);
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, hr);
  endtask

  // Push this cycle's expectation, advance one clock, then apply the counter bumps it causes.
  task automatic tick(input logic [6:0] ctrl, input logic bump_s, input logic bump_f,
                      input string nm);
    exp_q.push_back({ctrl, exp_stall, exp_flush});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (STATS && bump_s && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    if (STATS && bump_f && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    chk("reset_outputs_idle", {C_IDLE, 16'd0, 16'd0});
    idle_in(1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    tick(C_IDLE, 0, 0, "run_idle");
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(C_STALL, 1, 0, "load_use_rn");
    idle_in(1'b0);
    tick(C_IDLE, 0, 0, "after_stall_count");
    set_in(4'd5, 4'd7, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(C_STALL, 1, 0, "load_use_rm");
    set_in(4'd2, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(C_IDLE, 0, 0, "rn_not_used");
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(C_IDLE, 0, 0, "load_no_write");
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(C_IDLE, 0, 0, "alu_producer");
    set_in(4'd3, 4'd4, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(C_IDLE, 0, 0, "reg_mismatch");

    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(C_STALL, 1, 0, "branch_with_load_use");
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(C_BRANCH, 0, 1, "branch_alone");
    idle_in(1'b0);
    tick(C_IDLE, 0, 0, "after_branch_count");

    // halt deferred behind load_use and branch, then drain and halt
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(C_STALL, 1, 0, "halt_deferred_load_use");
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(C_BRANCH, 0, 1, "halt_deferred_branch");
    idle_in(1'b1);
    tick(C_HENTRY, 0, 0, "halt_entry");
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(C_DRAIN, 0, 0, "drain_1_ignores_hazards");
    tick(C_DRAIN, 0, 0, "drain_2");
    tick(C_DRAIN, 0, 0, "drain_3");
    tick(C_HALTED, 0, 0, "halted_1_ignores_hazards");
    idle_in(1'b1);
    tick(C_HALTED, 0, 0, "halted_2");
    idle_in(1'b0);
    tick(C_HALTED, 0, 0, "halt_release_cycle");
    tick(C_IDLE, 0, 0, "resume_run");

    // drain length is fixed even if halt_req drops immediately
    idle_in(1'b1);
    tick(C_HENTRY, 0, 0, "halt_entry_short");
    idle_in(1'b0);
    tick(C_DRAIN, 0, 0, "short_drain_1");
    tick(C_DRAIN, 0, 0, "short_drain_2");
    tick(C_DRAIN, 0, 0, "short_drain_3");
    tick(C_HALTED, 0, 0, "short_halted");
    tick(C_IDLE, 0, 0, "short_resume");

    // asynchronous reset in the second drain cycle
    idle_in(1'b1);
    tick(C_HENTRY, 0, 0, "halt_entry_rst");
    tick(C_DRAIN, 0, 0, "rst_drain_1");
    #1;
    chk("second_drain_cycle", {C_DRAIN, exp_stall, exp_flush});
    reset = 1'b0;
    #1;
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    chk("async_reset_mid_drain", {C_IDLE, 16'd0, 16'd0});
    idle_in(1'b0);
    @(posedge clk); #1;
    chk("reset_held_over_edge", {C_IDLE, 16'd0, 16'd0});
    reset = 1'b1;
    tick(C_IDLE, 0, 0, "run_after_reset");

    // saturation: 65536 consecutive load_use bubbles
    set_in(4'd9, 4'd9, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (65536) @(posedge clk);
    #1;
    exp_stall = STATS ? 16'hFFFF : 16'd0;
    chk("stall_saturated", {C_STALL, exp_stall, exp_flush});
    tick(C_STALL, 1, 0, "stall_holds_max");
    idle_in(1'b0);
    tick(C_IDLE, 0, 0, "after_saturation");

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: id_rn, id_rm  in  4 each  source registers of the instruction in ID.
REQ-004 SHALL have port: id_uses_rn, id_uses_rm  in  1 each  source actually read.
REQ-005 SHALL have port: ex_rd  in  4  destination register of the instruction in EX.
REQ-006 SHALL have port: ex_mem_to_reg  in  1  EX instruction is a load.
REQ-007 SHALL have port: ex_reg_write  in  1  EX instruction writes the register file.
REQ-008 SHALL have port: id_branch_taken  in  1  branch resolved taken in ID.
REQ-009 SHALL have port: halt_req  in  1  level request to halt fetch and drain the pipeline.
REQ-010 SHALL have port: pc_enable  out  1  program counter update enable.
REQ-011 SHALL have port: if_id_enable  out  1  IF/ID register load enable.
REQ-012 SHALL have port: if_id_flush  out  1  IF/ID loads all-zero NOP.
REQ-013 SHALL have port: nop_select  out  1  cu_mux forces all control outputs to 0 (bubble into ID/EX).
REQ-014 SHALL have port: halt_ack  out  1  pipeline empty and halted.
REQ-015 SHALL have ports: stall_count, flush_count  out  16 each  statistics counters.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN, HALTED, encoded in 2 bits.
REQ-017 load_use SHALL be ex_mem_to_reg & ex_reg_write & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
REQ-018 In RUN with no event: pc_enable=1, if_id_enable=1, if_id_flush=0, nop_select=0, halt_ack=0.
REQ-019 In RUN with load_use: same cycle pc_enable=0, if_id_enable=0, nop_select=1; one bubble per detection.
REQ-020 In RUN with id_branch_taken and no load_use: same cycle if_id_flush=1, pc_enable=1, nop_select=0.
REQ-021 Priority SHALL be load_use > id_branch_taken > halt entry; a deferred halt_req is re-evaluated next cycle.
REQ-022 Halt entry (RUN, halt_req=1, no load_use, no branch): pc_enable=0, if_id_flush=1; the ID instruction proceeds; next state DRAIN, drain counter loaded with 3.
REQ-023 In DRAIN: pc_enable=0, if_id_enable=0, nop_select=1; counter decrements each cycle; at counter==1 next state is HALTED.
REQ-024 DRAIN SHALL last exactly 3 cycles regardless of halt_req.
REQ-025 In HALTED: halt_ack=1, pc_enable=0, if_id_enable=0, nop_select=1; stay while halt_req=1.
REQ-026 In HALTED with halt_req=0: next state RUN; halt_ack falls on that edge; PC resumes at the un-fetched address.
REQ-027 id_ex_*/load_use/branch inputs SHALL be ignored in DRAIN and HALTED.
REQ-028 All outputs except counters SHALL be combinational from state and current inputs.

Reset
REQ-029 reset=0 SHALL force state RUN, drain counter 0, stall_count=0, flush_count=0 immediately, including mid-DRAIN or HALTED.
REQ-030 During reset, outputs SHALL follow the RUN/no-event values (halt_ack=0).

Configuration
REQ-031 With macro HAZARD_STATS_EN defined: stall_count increments on each load_use bubble cycle; flush_count increments on each branch flush cycle; both saturate at 16'hFFFF.
REQ-032 Without HAZARD_STATS_EN: stall_count and flush_count SHALL be constant 0 and no counter registers exist.

Verification
REQ-033 ex_mem_to_reg=1, ex_reg_write=1, ex_rd=2, id_rn=2, id_uses_rn=1 for 1 cycle -> pc_enable=0, if_id_enable=0, nop_select=1 that cycle; stall_count=1 (stats on).
REQ-034 Same as REQ-033 but id_uses_rn=0 -> no stall, pc_enable=1.
REQ-035 id_branch_taken=1 with load_use=1 same cycle -> stall only, if_id_flush=0; next cycle branch alone -> if_id_flush=1, flush_count=1.
REQ-036 halt_req=1 held from cycle N -> cycle N if_id_flush=1, pc_enable=0; cycles N+1..N+3 nop_select=1; halt_ack=1 from N+4; halt_req=0 at M -> halt_ack=0 and pc_enable=1 from M+1.
REQ-037 reset=0 asserted in second DRAIN cycle -> state RUN, halt_ack=0, counters 0 asynchronously.
REQ-038 Force 65536 load_use cycles with stats on -> stall_count holds 16'hFFFF; stats off -> stall_count stays 0.
